// File: rtl/opl3_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : opl3_i2s_tx
// Brief   : Stereo-pair FIFO feeding a Philips I2S serialiser with internal BCLK/LRCLK.
// Revision: 1.0
// ============================================================================
module opl3_i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [DATA_WIDTH-1:0]         sample_l,
    input  logic [DATA_WIDTH-1:0]         sample_r,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic                          overflow,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int C_AW     = $clog2(FIFO_DEPTH);
    localparam int C_DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int C_PAIR_W = 2 * DATA_WIDTH;
    localparam logic [C_AW:0]      C_LEVEL_FULL = (C_AW + 1)'(FIFO_DEPTH);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST   = C_DIV_W'(BCLK_DIV - 1);

    logic [C_DIV_W-1:0]  r_div_cnt;
    logic [5:0]          r_bit_cnt;
    logic [C_PAIR_W-1:0] r_mem [FIFO_DEPTH];
    logic [C_AW-1:0]     r_wr_ptr;
    logic [C_AW-1:0]     r_rd_ptr;
    logic [C_AW:0]       r_level;
    logic [C_PAIR_W-1:0] r_held;
    logic [63:0]         r_frame;

    logic                w_tick;
    logic                w_fall;
    logic                w_wrap;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic [5:0]          w_bit_nxt;
    logic [C_PAIR_W-1:0] w_pair;
    logic [31:0]         w_left_slot;
    logic [31:0]         w_right_slot;
    logic [63:0]         w_frame;

    assign w_tick    = (r_div_cnt == C_DIV_LAST);
    assign w_fall    = w_tick && i2s_bclk;
    assign w_wrap    = w_fall && (r_bit_cnt == 6'd63);
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == C_LEVEL_FULL);
    assign w_pop     = w_wrap && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push    = sample_valid && (!w_full || w_pop);
    assign w_bit_nxt = r_bit_cnt + 6'd1;

    // Frame bit k sits at w_frame[63-k]; each slot leads with the one-BCLK I2S delay bit.
    assign w_pair       = w_pop ? r_mem[r_rd_ptr] : r_held;
    assign w_left_slot  = 32'(w_pair[C_PAIR_W-1 -: DATA_WIDTH]) << (31 - DATA_WIDTH);
    assign w_right_slot = 32'(w_pair[DATA_WIDTH-1:0]) << (31 - DATA_WIDTH);
    assign w_frame      = {w_left_slot, w_right_slot};

    assign fifo_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {sample_l, sample_r};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_held    <= '0;
            r_frame   <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= sample_valid && w_full && !w_pop;
            underflow <= w_wrap && w_empty;

            r_div_cnt <= w_tick ? '0 : r_div_cnt + C_DIV_W'(1);
            if (w_tick) begin
                i2s_bclk <= ~i2s_bclk;
            end

            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                i2s_lrclk <= w_bit_nxt[5];
                if (w_wrap) begin
                    r_frame   <= {w_frame[62:0], 1'b0};
                    i2s_sdata <= w_frame[63];
                end else begin
                    r_frame   <= {r_frame[62:0], 1'b0};
                    i2s_sdata <= r_frame[63];
                end
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
                r_held   <= r_mem[r_rd_ptr];
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            r_level <= r_level + {{C_AW{1'b0}}, w_push} - {{C_AW{1'b0}}, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opl3_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_opl3_i2s_tx
// Brief   : Self-checking bench for opl3_i2s_tx against a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_opl3_i2s_tx;

    localparam int DW        = 16;
    localparam int DEPTH     = 4;
    localparam int DIV       = 2;
    localparam int FRAME_CLK = 2 * DIV * 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_l = '0;
    logic [DW-1:0] sample_r = '0;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic          overflow;
    logic          underflow;
    logic [2:0]    fifo_level;

    int checks = 0;
    int errors = 0;

    opl3_i2s_tx #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .BCLK_DIV   (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .overflow     (overflow),
        .underflow    (underflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: time since reset release, a queue of pairs, and the pair on air.
    int          t;
    logic [31:0] q[$];
    logic [31:0] held;
    logic [31:0] cur;
    logic        e_bclk, e_lrclk, e_sdata, e_ovf, e_udf;
    logic [2:0]  e_level;

    task automatic model_reset();
        t = 0;
        q.delete();
        held = '0;
        cur = '0;
        {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf} = '0;
        e_level = '0;
    endtask

    task automatic step();
        logic        v;
        logic [31:0] in_pair;
        int          pre, k;
        bit          wrap, pop, acc;
        v = sample_valid;
        in_pair = {sample_l, sample_r};
        @(posedge clk);
        t++;
        wrap = (t % FRAME_CLK) == 0;
        pre = q.size();
        pop = wrap && (pre > 0);
        e_udf = wrap && (pre == 0);
        if (wrap) begin
            if (pop) begin
                cur = q.pop_front();
                held = cur;
            end else begin
                cur = held;
            end
        end
        acc = v && ((pre < DEPTH) || pop);
        e_ovf = v && !acc;
        if (acc) q.push_back(in_pair);
        e_level = 3'(q.size());
        e_bclk = ((t / DIV) % 2) == 1;
        k = (t / (2 * DIV)) % 64;
        e_lrclk = k >= 32;
        if (k >= 1 && k <= DW)
            e_sdata = cur[2 * DW - k];
        else if (k >= 33 && k <= 32 + DW)
            e_sdata = cur[32 + DW - k];
        else
            e_sdata = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int ucount, first_u;
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pins got %b want 00000",
                     {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow});
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_level got %0d want 0", fifo_level);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        ucount = 0;
        first_u = -1;
        for (int i = 0; i < 3 * FRAME_CLK; i++) begin
            step();
            if (underflow === 1'b1) begin
                ucount++;
                if (first_u < 0) first_u = t;
            end
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf}) begin
                errors++;
                $display("FAIL idle_pins t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf});
            end
            checks++;
            if (fifo_level !== e_level) begin
                errors++;
                $display("FAIL idle_level t=%0d got %0d want %0d", t, fifo_level, e_level);
            end
        end
        checks++;
        if (ucount !== 3) begin
            errors++;
            $display("FAIL idle_underflow_count got %0d want 3", ucount);
        end
        checks++;
        if (first_u !== FRAME_CLK) begin
            errors++;
            $display("FAIL idle_first_underflow got t=%0d want t=%0d", first_u, FRAME_CLK);
        end
    endtask

    task automatic test_single_pair();
        logic [63:0] cap_d, cap_lr, want_d, want_lr, want_l, want_r;
        logic        prev_b;
        int          k;
        do_reset();
        want_l = 64'h0000_0000_0000_A5C3;
        want_r = 64'h0000_0000_0000_8001;
        want_d = (want_l << 47) | (want_r << 15);
        want_lr = 64'h0000_0000_FFFF_FFFF;
        cap_d = '0;
        cap_lr = '0;
        for (int i = 0; i < 2 * FRAME_CLK + 8; i++) begin
            if (i == 50) begin
                sample_valid = 1'b1;
                sample_l = 16'hA5C3;
                sample_r = 16'h8001;
            end else begin
                sample_valid = 1'b0;
            end
            prev_b = i2s_bclk;
            step();
            if (!prev_b && i2s_bclk && (t / FRAME_CLK) == 1) begin
                k = (t / (2 * DIV)) % 64;
                cap_d[63 - k] = i2s_sdata;
                cap_lr[63 - k] = i2s_lrclk;
            end
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf}) begin
                errors++;
                $display("FAIL pair_pins t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf});
            end
            checks++;
            if (fifo_level !== e_level) begin
                errors++;
                $display("FAIL pair_level t=%0d got %0d want %0d", t, fifo_level, e_level);
            end
        end
        checks++;
        if (cap_d !== want_d) begin
            errors++;
            $display("FAIL pair_frame_bits got %h want %h", cap_d, want_d);
        end
        checks++;
        if (cap_lr !== want_lr) begin
            errors++;
            $display("FAIL pair_lrclk_bits got %h want %h", cap_lr, want_lr);
        end
    endtask

    // Five pushes right after a wrap, then drain through one repeated frame.
    task automatic test_overflow_and_drain();
        int ovf_at, ucount;
        do_reset();
        ovf_at = -1;
        ucount = 0;
        for (int i = 0; i < 6 * FRAME_CLK + 20; i++) begin
            if (i >= FRAME_CLK + 4 && i < FRAME_CLK + 9) begin
                sample_valid = 1'b1;
                sample_l = DW'($urandom);
                sample_r = DW'($urandom);
            end else begin
                sample_valid = 1'b0;
            end
            step();
            if (overflow === 1'b1 && ovf_at < 0) ovf_at = i;
            if (underflow === 1'b1 && t > 5 * FRAME_CLK) ucount++;
            if (i == FRAME_CLK + 9) begin
                checks++;
                if (fifo_level !== 3'd4) begin
                    errors++;
                    $display("FAIL ovf_level_full got %0d want 4", fifo_level);
                end
            end
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf}) begin
                errors++;
                $display("FAIL ovf_pins t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf});
            end
            checks++;
            if (fifo_level !== e_level) begin
                errors++;
                $display("FAIL ovf_level t=%0d got %0d want %0d", t, fifo_level, e_level);
            end
        end
        checks++;
        if (ovf_at !== FRAME_CLK + 8) begin
            errors++;
            $display("FAIL ovf_fifth_push got iter %0d want %0d", ovf_at, FRAME_CLK + 8);
        end
        checks++;
        if (ucount !== 1) begin
            errors++;
            $display("FAIL drain_underflow_count got %0d want 1", ucount);
        end
    endtask

    task automatic test_full_wrap_push();
        int guard;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            sample_valid = (i >= 10);
            sample_l = DW'($urandom);
            sample_r = DW'($urandom);
            step();
        end
        sample_valid = 1'b0;
        guard = 0;
        while (((t + 1) % FRAME_CLK) != 0 && guard < 2 * FRAME_CLK) begin
            guard++;
            step();
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level}) begin
                errors++;
                $display("FAIL wrap_fill t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level});
            end
        end
        sample_valid = 1'b1;
        sample_l = DW'($urandom);
        sample_r = DW'($urandom);
        step();
        sample_valid = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_push_overflow got %b want 0", overflow);
        end
        checks++;
        if (fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL wrap_push_level got %0d want 4", fifo_level);
        end
        for (int i = 0; i < FRAME_CLK + 8; i++) begin
            step();
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level}) begin
                errors++;
                $display("FAIL wrap_after t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level});
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard, ucount;
        do_reset();
        guard = 0;
        while (!(t > FRAME_CLK && ((t / (2 * DIV)) % 64) == 40 && i2s_bclk === 1'b1)
               && guard < 3 * FRAME_CLK) begin
            sample_valid = (guard == 20 || guard == 21);
            sample_l = DW'($urandom);
            sample_r = DW'($urandom);
            guard++;
            step();
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level}) begin
                errors++;
                $display("FAIL mid_pre t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level});
            end
        end
        sample_valid = 1'b0;
        checks++;
        if (guard >= 3 * FRAME_CLK) begin
            errors++;
            $display("FAIL mid_timeout got %0d cycles want < %0d", guard, 3 * FRAME_CLK);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level} !== 6'b0) begin
            errors++;
            $display("FAIL mid_async_clear got %b want 000000",
                     {i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level});
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        ucount = 0;
        for (int i = 0; i < 2 * FRAME_CLK + 4; i++) begin
            step();
            if (underflow === 1'b1) ucount++;
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level}) begin
                errors++;
                $display("FAIL mid_post t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, fifo_level},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf, e_level});
            end
        end
        checks++;
        if (ucount !== 2) begin
            errors++;
            $display("FAIL mid_underflow_count got %0d want 2", ucount);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 8 * FRAME_CLK; i++) begin
            sample_valid = ($urandom_range(0, 99) < 4);
            sample_l = DW'($urandom);
            sample_r = DW'($urandom);
            step();
            checks++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow} !==
                {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf}) begin
                errors++;
                $display("FAIL rand_pins t=%0d got %b want %b", t,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow},
                         {e_bclk, e_lrclk, e_sdata, e_ovf, e_udf});
            end
            checks++;
            if (fifo_level !== e_level) begin
                errors++;
                $display("FAIL rand_level t=%0d got %0d want %0d", t, fifo_level, e_level);
            end
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pair();
        test_overflow_and_drain();
        test_full_wrap_push();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
